count_uart_tx: RTL and testbench
================================

COUNT_UART_TX -- requirements
Module: count_uart_tx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 87, meaning clk cycles per UART bit (10 MHz clk, ~115200 baud); legal range 2..65535.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port in_data  input  8  byte to send (counter value from the upstream counter stage).
REQ-005 SHALL have port in_valid  input  1  in_data is offered this cycle.
REQ-006 SHALL have port in_ready  output  1  block can accept a byte this cycle.
REQ-007 SHALL have port tx  output  1  serial line, idle high.
REQ-008 SHALL have port busy  output  1  frame in progress.

Function
REQ-009 SHALL transmit 8N1 frames: one start bit (0), 8 data bits LSB first, one stop bit (1), each bit held exactly CLKS_PER_BIT cycles.
REQ-010 SHALL implement states IDLE, START, DATA, STOP; IDLE->START on accept, START->DATA after CLKS_PER_BIT cycles, DATA->STOP after 8th bit period, STOP->IDLE after CLKS_PER_BIT cycles.
REQ-011 SHALL assert in_ready exactly when state is IDLE; busy SHALL equal NOT in_ready.
REQ-012 SHALL accept a byte only on a cycle with in_valid=1 and in_ready=1, capturing in_data into an internal shift register on that edge.
REQ-013 SHALL drive tx low starting the cycle after acceptance (1-cycle latency from accept edge to start bit).
REQ-014 SHALL occupy exactly 10*CLKS_PER_BIT cycles from first start-bit cycle to last stop-bit cycle, then show in_ready=1 on the following cycle.
REQ-015 SHALL allow back-to-back frames: with in_valid held high, the next start bit follows the previous stop bit after exactly one idle-high cycle.
REQ-016 SHALL ignore in_valid and in_data while busy; no byte is queued, and changes to in_data after acceptance do not affect the frame in flight.
REQ-017 SHALL use a baud counter of width clog2(CLKS_PER_BIT) counting 0..CLKS_PER_BIT-1 and wrapping to 0, and a 3-bit bit index wrapping 7->0 on DATA->STOP.
REQ-018 SHALL drive tx from a register (no combinational path from in_data or in_valid to tx).
REQ-019 SHALL hold tx=1 at all times in IDLE, including while in_valid=0.

Reset
REQ-020 SHALL, while rst=1 on a clock edge, force state=IDLE, tx=1, busy=0, in_ready=1, baud counter=0, bit index=0, shift register=0x00.
REQ-021 SHALL abort any frame when rst is asserted mid-frame: tx reads 1 from the cycle after the reset edge, with no partial bits resumed after release.
REQ-022 SHALL NOT accept a byte on a cycle where rst=1, even if in_valid=1.

Structure
REQ-023 SHALL place the state enumeration (IDLE, START, DATA, STOP) and the default CLKS_PER_BIT constant in shared package uart_pkg.
REQ-024 SHALL factor the baud counter into one sub-module, uart_baud_tick, emitting a 1-cycle tick at count CLKS_PER_BIT-1 and restarting on a clear input asserted at accept.

Verification (bench uses CLKS_PER_BIT=4)
REQ-025 SHALL cover: send 0x55 -> tx = 0,1,0,1,0,1,0,1,0,1 each held 4 cycles; in_ready low for 40 cycles, high on cycle 41.
REQ-026 SHALL cover: send 0x00 then 0xFF with in_valid held high -> 0x00 frame, one idle-high cycle, 0xFF frame (start 0, eight 1s, stop 1).
REQ-027 SHALL cover: in_valid pulsed with 0xA3 at cycle 10 of a 0x3C frame -> only 0x3C transmitted; 0xA3 never appears on tx.
REQ-028 SHALL cover: rst asserted during data bit 4 of 0xF0 -> tx=1, busy=0, in_ready=1 the cycle after; next accepted 0x81 frames correctly.
REQ-029 SHALL cover: in_data changed from 0x12 to 0xED one cycle after accept -> 0x12 transmitted.
REQ-030 SHALL cover: in_valid=1 with rst=1 -> no accept; tx stays 1, busy stays 0.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the counter-value UART transmitter.
package uart_pkg;

  // Default bit period: 10 MHz clock at roughly 115200 baud.
  localparam int DEFAULT_CLKS_PER_BIT = 87;

  // Transmitter frame states.
  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } tx_state_t;

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and pulses tick on the last count.
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] count;

  assign tick = (count == LAST);

  // Free-running modulo counter, restarted at frame acceptance so the start bit gets a full period.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst || clear) begin
      count <= '0;
    end else if (tick) begin
      count <= '0;
    end else begin
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/count_uart_tx.sv
// 8N1 UART transmitter for bytes from the upstream counter stage.
module count_uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       tx,
  output logic       busy
);

  tx_state_t  state;
  logic [7:0] shreg;
  logic [2:0] bit_idx;
  logic       tick;
  logic       accept;

  // Ready is a pure decode of the state register, so it never depends on in_valid.
  assign in_ready = (state == IDLE);
  assign busy     = ~in_ready;
  assign accept   = in_ready & in_valid & ~rst;

  uart_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk  (clk),
    .rst  (rst),
    .clear(accept),
    .tick (tick)
  );

  // Frame sequencer: tx is registered and updated only on state or bit boundaries.
  always_ff @(posedge clk) begin
    // NOTE: reset clears every register including the shift register, so an aborted frame leaves no residue.
    if (rst) begin
      state   <= IDLE;
      tx      <= 1'b1;
      shreg   <= 8'h00;
      bit_idx <= 3'd0;
    end else begin
      unique case (state)
        IDLE: begin
          tx <= 1'b1;
          if (in_valid) begin
            state   <= START;
            tx      <= 1'b0;
            shreg   <= in_data;
            bit_idx <= 3'd0;
          end
        end
        START: begin
          if (tick) begin
            state <= DATA;
            tx    <= shreg[0];
            shreg <= {1'b0, shreg[7:1]};
          end
        end
        DATA: begin
          if (tick) begin
            if (bit_idx == 3'd7) begin
              state   <= STOP;
              tx      <= 1'b1;
              bit_idx <= 3'd0;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              tx      <= shreg[0];
              shreg   <= {1'b0, shreg[7:1]};
            end
          end
        end
        STOP: begin
          tx <= 1'b1;
          if (tick) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          tx    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_count_uart_tx.sv
// Directed bench for count_uart_tx with a 4-cycle bit period.
module tb_count_uart_tx;

  localparam int CPB   = 4;
  localparam int FRAME = 10 * CPB;

  logic       clk;
  logic       rst;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       tx;
  logic       busy;

  int checks = 0;
  int errors = 0;

  count_uart_tx #(
    .CLKS_PER_BIT(CPB)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .in_data (in_data),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .tx      (tx),
    .busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected tx waveform, one entry per clock: start 0, data LSB first, stop 1.
  function automatic logic [FRAME-1:0] frame_bits(input logic [7:0] b);
    logic [FRAME-1:0] v;
    for (int i = 0; i < FRAME; i++) begin
      int k;
      k = i / CPB;
      if (k == 0)      v[i] = 1'b0;
      else if (k == 9) v[i] = 1'b1;
      else             v[i] = b[k-1];
    end
    return v;
  endfunction

  // Records outputs at the next FRAME falling edges.
  task automatic capture(output logic [FRAME-1:0] txs, output logic [FRAME-1:0] rdys,
                         output logic [FRAME-1:0] bsys);
    for (int i = 0; i < FRAME; i++) begin
      @(negedge clk);
      txs[i]  = tx;
      rdys[i] = in_ready;
      bsys[i] = busy;
    end
  endtask

  // Presents a byte while idle; the frame starts at the following falling edge.
  task automatic offer(input logic [7:0] b, input logic hold);
    in_data  = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) in_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (tx !== 1'b1 || busy !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_state: tx=%b busy=%b in_ready=%b want 1 0 1", tx, busy, in_ready);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (tx !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: tx=%b busy=%b want 1 0", tx, busy);
    end
  endtask

  task automatic test_valid_during_reset;
    rst      = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'h00;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (tx !== 1'b1 || busy !== 1'b0 || in_ready !== 1'b1) begin
        errors++;
        $display("FAIL valid_in_reset[%0d]: tx=%b busy=%b in_ready=%b want 1 0 1", i, tx, busy, in_ready);
      end
    end
    rst      = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (tx !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL valid_in_reset_release: tx=%b busy=%b want 1 0", tx, busy);
    end
  endtask

  task automatic test_frame_55;
    logic [FRAME-1:0] t, r, b;
    offer(8'h55, 1'b0);
    capture(t, r, b);
    checks++;
    if (t !== frame_bits(8'h55)) begin
      errors++;
      $display("FAIL frame_55_tx: got %h want %h", t, frame_bits(8'h55));
    end
    checks++;
    if (r !== '0) begin
      errors++;
      $display("FAIL frame_55_ready_low: got %h want 0", r);
    end
    checks++;
    if (b !== '1) begin
      errors++;
      $display("FAIL frame_55_busy_high: got %h want all ones", b);
    end
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0 || tx !== 1'b1) begin
      errors++;
      $display("FAIL frame_55_cycle41: in_ready=%b busy=%b tx=%b want 1 0 1", in_ready, busy, tx);
    end
  endtask

  task automatic test_back_to_back;
    logic [FRAME-1:0] t, r, b;
    offer(8'h00, 1'b1);
    in_data = 8'hFF;
    capture(t, r, b);
    checks++;
    if (t !== frame_bits(8'h00)) begin
      errors++;
      $display("FAIL b2b_frame_00: got %h want %h", t, frame_bits(8'h00));
    end
    @(negedge clk);
    checks++;
    if (tx !== 1'b1 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_gap: tx=%b in_ready=%b want 1 1", tx, in_ready);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    capture(t, r, b);
    checks++;
    if (t !== frame_bits(8'hFF)) begin
      errors++;
      $display("FAIL b2b_frame_ff: got %h want %h", t, frame_bits(8'hFF));
    end
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_end_idle: in_ready=%b want 1", in_ready);
    end
  endtask

  task automatic test_ignore_busy;
    logic [FRAME-1:0] t, r, b;
    offer(8'h3C, 1'b0);
    fork
      capture(t, r, b);
      begin
        repeat (10) @(negedge clk);
        in_data  = 8'hA3;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
      end
    join
    checks++;
    if (t !== frame_bits(8'h3C)) begin
      errors++;
      $display("FAIL ignore_busy_frame: got %h want %h", t, frame_bits(8'h3C));
    end
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL ignore_busy_idle: in_ready=%b want 1", in_ready);
    end
    capture(t, r, b);
    checks++;
    if (t !== '1 || b !== '0) begin
      errors++;
      $display("FAIL ignore_busy_no_queue: tx=%h busy=%h want all ones / 0", t, b);
    end
  endtask

  task automatic test_reset_abort;
    logic [FRAME-1:0] t, r, b;
    offer(8'hF0, 1'b0);
    // Samples 20..23 carry data bit 4; assert reset in its middle.
    repeat (22) @(negedge clk);
    checks++;
    if (tx !== 1'b1) begin
      errors++;
      $display("FAIL abort_pre_bit4: tx=%b want 1", tx);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (tx !== 1'b1 || busy !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL abort_after_rst: tx=%b busy=%b in_ready=%b want 1 0 1", tx, busy, in_ready);
    end
    rst = 1'b0;
    capture(t, r, b);
    checks++;
    if (t !== '1 || b !== '0) begin
      errors++;
      $display("FAIL abort_no_resume: tx=%h busy=%h want all ones / 0", t, b);
    end
    offer(8'h81, 1'b0);
    capture(t, r, b);
    checks++;
    if (t !== frame_bits(8'h81)) begin
      errors++;
      $display("FAIL abort_next_81: got %h want %h", t, frame_bits(8'h81));
    end
    @(negedge clk);
  endtask

  task automatic test_data_change;
    logic [FRAME-1:0] t, r, b;
    in_data  = 8'h12;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = 8'hED;
    capture(t, r, b);
    checks++;
    if (t !== frame_bits(8'h12)) begin
      errors++;
      $display("FAIL data_change_frame: got %h want %h", t, frame_bits(8'h12));
    end
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || tx !== 1'b1) begin
      errors++;
      $display("FAIL data_change_idle: in_ready=%b tx=%b want 1 1", in_ready, tx);
    end
  endtask

  initial begin
    test_reset();
    test_valid_during_reset();
    test_frame_55();
    test_back_to_back();
    test_ignore_busy();
    test_reset_abort();
    test_data_change();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
